instr_fetch: RTL
================

// Module: instr_fetch
// PURPOSE
//  Instruction fetch stage. Owns the PC, issues word requests to instruction memory over a
//  valid/ready port, and presents each fetched instruction with its PC to the decode stage.
//  if_opcode (if_instr[31:26]) drives the main control unit's opcode input.
//  A redirect port (branch/jump target from EX) overrides sequential PC+4 fetch.
// PARAMETERS
//  PC_RESET  32'h0000_0000  PC loaded on reset; bits [1:0] must be 0
// PORTS
//  clk             in   1   clock, all state updates on rising edge
//  rst             in   1   reset, synchronous, active-high
//  imem_req_valid  out  1   fetch request valid
//  imem_req_ready  in   1   memory accepts request
//  imem_req_addr   out  32  word address of request (byte address, [1:0]=0)
//  imem_rsp_valid  in   1   response valid (exactly one per accepted request, >=1 cycle later)
//  imem_rsp_data   in   32  instruction word
//  redirect_valid  in   1   taken branch/jump this cycle
//  redirect_pc     in   32  new PC; bits [1:0] ignored (forced 0)
//  if_valid        out  1   instruction available to decode
//  if_ready        in   1   decode accepts instruction
//  if_instr        out  32  instruction word
//  if_pc           out  32  byte address of if_instr
//  if_opcode       out  6   if_instr[31:26]
// BEHAVIOUR
//  - One clock, synchronous active-high reset. At most one request outstanding.
//  - Registers: pc (next fetch addr), req_pc, out buffer {if_valid, if_instr, if_pc}, state.
//  - Reset: pc=PC_RESET, state=REQ, if_valid=0, if_instr=0, if_pc=0; imem_req_valid=0 while
//    rst=1. The instruction memory shares rst; responses pending at reset are never delivered.
//  - States: REQ (may issue), WAIT (one request in flight), DROP (in-flight response unwanted).
//  - REQ: imem_req_valid = !rst && !redirect_valid && (!if_valid || if_ready);
//    imem_req_addr = pc. On request handshake: req_pc<=pc, pc<=pc+4 (mod 2^32), -> WAIT.
//    The issue condition guarantees the out buffer is empty while in WAIT.
//  - WAIT: on imem_rsp_valid: if_instr<=imem_rsp_data, if_pc<=req_pc, if_valid<=1, -> REQ.
//  - DROP: on imem_rsp_valid: discard data, -> REQ.
//  - Out buffer: if_valid holds and if_instr/if_pc stay stable until if_ready=1; handshake
//    (if_valid && if_ready) clears if_valid unless reloaded the same cycle.
//  - Redirect (highest priority, any state): pc<={redirect_pc[31:2],2'b00}; if_valid<=0
//    (buffered instruction squashed, even if being handshaken that cycle); no request issued
//    that cycle. State: REQ->REQ; WAIT->DROP, or ->REQ if imem_rsp_valid same cycle (rsp
//    discarded); DROP->DROP, or ->REQ if imem_rsp_valid same cycle.
//  - Throughput: 1 instr / 2 cycles with a 1-cycle-latency memory and if_ready=1.
//  - Latency: request accepted at cycle N, response at N+k -> if_valid high from N+k+1.
//  - PC wraps 32'hFFFF_FFFC -> 32'h0000_0000 silently.
// TESTING
//  T1 reset: rst=1 two cycles, release -> first req addr=PC_RESET, if_valid=0 until first rsp.
//  T2 stream: 1-cycle memory, if_ready=1, rsp=addr+0x1000 -> if_pc 0,4,8,..., instr matches,
//     if_valid pulses every 2 cycles, no skipped/duplicated PC.
//  T3 backpressure: if_ready=0 for 5 cycles with if_valid=1 -> no new request, if_instr/if_pc
//     stable; if_ready=1 -> handshake, next request issued same cycle.
//  T4 redirect in WAIT: req at 0x8 accepted, redirect_pc=0x43 next cycle, rsp 3 cycles later ->
//     rsp dropped, next request addr=0x40, next if_pc=0x40.
//  T5 redirect+rsp same cycle, and redirect while if_valid=1 -> neither instruction appears at
//     decode; next request addr=target.
//  T6 wrap: PC_RESET=32'hFFFF_FFFC -> if_pc FFFF_FFFC then 0000_0000; rst mid-WAIT -> restart at PC_RESET.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues single outstanding word requests to
// instruction memory and buffers each returned instruction, with its PC, for decode.
module instr_fetch #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [5:0]  if_opcode
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;

  logic req_fire;
  logic out_hs;

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    req_pc_d       = req_pc_q;
    if_valid_d     = if_valid_q;
    if_instr_d     = if_instr_q;
    if_pc_d        = if_pc_q;
    // Only issue when the out buffer is free (or draining) so WAIT never sees it full
    imem_req_valid = (state_q == S_REQ) && !rst && !redirect_valid &&
                     (!if_valid_q || if_ready);
    imem_req_addr  = pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    out_hs         = if_valid_q && if_ready;

    if (redirect_valid) begin
      pc_d       = redirect_pc & ~32'd3;
      if_valid_d = 1'b0;
      unique case (state_q)
        S_WAIT, S_DROP: state_d = imem_rsp_valid ? S_REQ : S_DROP;
        default:        state_d = S_REQ;
      endcase
    end else begin
      if (out_hs) if_valid_d = 1'b0;
      unique case (state_q)
        S_REQ: begin
          if (req_fire) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + 32'd4;
            state_d  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if_instr_d = imem_rsp_data;
            if_pc_d    = req_pc_q;
            if_valid_d = 1'b1;
            state_d    = S_REQ;
          end
        end
        S_DROP: begin
          if (imem_rsp_valid) state_d = S_REQ;
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      pc_q       <= PC_RESET;
      if_valid_q <= 1'b0;
      if_instr_q <= 32'd0;
      if_pc_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
    end
  end

  // req_pc is only consumed after a request handshake, so it needs no reset
  always_ff @(posedge clk) begin
    req_pc_q <= req_pc_d;
  end

  assign if_valid  = if_valid_q;
  assign if_instr  = if_instr_q;
  assign if_pc     = if_pc_q;
  assign if_opcode = if_instr_q[31:26];

endmodule
